// File: rtl/disp_pkg.sv
// Shared constants and state type for the display source sequencer.
package disp_pkg;

    localparam logic [7:0]  SEG_E     = 8'h86;
    localparam logic [7:0]  SEG_R     = 8'hAF;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    // "Err" right-aligned on digits 2..0, remaining digits blank
    localparam logic [63:0] ERR_WORD  = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                         SEG_BLANK, SEG_E, SEG_R, SEG_R};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/disp_src_seq_if.sv
// Debug read port handshake: req/addr from the sequencer, ack/data from the memory side.
interface disp_src_seq_if #(
    parameter int ADDR_W = 5
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [31:0]       rd_data;

    modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/disp_src_seq_step_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for an asynchronous button level.
module step_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d_async,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;

    // Bring the level into the clk domain and flag each 0->1 transition for one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= d_async;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/disp_src_seq.sv
// Walks a window of the debug read port one entry at a time and presents each word to the display driver.
module disp_src_seq
    import disp_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int NUM_ENTRIES = 32,
    parameter int HOLD_CYC    = 50000000,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           run,
    input  logic                           step,
    input  logic [ADDR_W-1:0]              base_addr,
    disp_src_seq_if.master                 rd,
    output logic [63:0]                    disp_data,
    output logic                           disp_mode,
    output logic [$clog2(NUM_ENTRIES)-1:0] cur_idx,
    output logic                           rd_err
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int HC_W  = $clog2(HOLD_CYC + 1);
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD_CYC - 1);
    localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(RD_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    state_e             state_r;
    logic               rd_req_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic [63:0]        disp_data_r;
    logic               disp_mode_r;
    logic [IDX_W-1:0]   cur_idx_r;
    logic               rd_err_r;
    logic [HC_W-1:0]    hold_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;

    logic               step_rise_s;
    logic               ack_s;
    logic               tmo_s;
    logic               adv_s;
    logic [IDX_W-1:0]   nxt_idx_s;

    // Window address: base plus index, wrapping within the address space
    function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        logic [ADDR_W+IDX_W-1:0] sum;
        sum = {{IDX_W{1'b0}}, base} + {{ADDR_W{1'b0}}, idx};
        return sum[ADDR_W-1:0];
    endfunction

    step_sync u_step_sync (
        .clk     (clk),
        .rstn    (rstn),
        .d_async (step),
        .rise    (step_rise_s)
    );

    // Exit conditions; an ack on the timeout cycle takes priority
    always_comb begin
        ack_s = 1'b0;
        tmo_s = 1'b0;
        adv_s = 1'b0;
        if (state_r == REQ) begin
            ack_s = rd.rd_ack;
            tmo_s = !rd.rd_ack && (to_cnt_r == TO_MAX);
        end else if (state_r == HOLD) begin
            adv_s = (run && (hold_cnt_r == HOLD_MAX)) || step_rise_s;
        end else begin
            ack_s = 1'b0;
            tmo_s = 1'b0;
            adv_s = 1'b0;
        end
    end

    // Next window index with wrap at the last entry
    always_comb begin
        nxt_idx_s = '0;
        if (cur_idx_r == IDX_LAST) begin
            nxt_idx_s = '0;
        end else begin
            nxt_idx_s = cur_idx_r + IDX_ONE;
        end
    end

    // Sequencer FSM with registered read port and display outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            rd_req_r    <= 1'b0;
            rd_addr_r   <= '0;
            disp_data_r <= 64'h0;
            disp_mode_r <= 1'b0;
            cur_idx_r   <= '0;
            rd_err_r    <= 1'b0;
            hold_cnt_r  <= '0;
            to_cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r   <= REQ;
                    rd_req_r  <= 1'b1;
                    rd_addr_r <= win_addr(base_addr, cur_idx_r);
                    to_cnt_r  <= '0;
                end
                REQ: begin
                    if (ack_s) begin
                        disp_data_r <= {32'h0, rd.rd_data};
                        disp_mode_r <= 1'b0;
                        rd_req_r    <= 1'b0;
                        hold_cnt_r  <= '0;
                        state_r     <= HOLD;
                    end else if (tmo_s) begin
                        disp_data_r <= ERR_WORD;
                        disp_mode_r <= 1'b1;
                        rd_err_r    <= 1'b1;
                        rd_req_r    <= 1'b0;
                        hold_cnt_r  <= '0;
                        state_r     <= HOLD;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                HOLD: begin
                    if (adv_s) begin
                        cur_idx_r <= nxt_idx_s;
                        rd_addr_r <= win_addr(base_addr, nxt_idx_s);
                        rd_req_r  <= 1'b1;
                        to_cnt_r  <= '0;
                        state_r   <= REQ;
                    end else if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_r <= hold_cnt_r + HC_ONE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    rd_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign rd.rd_req  = rd_req_r;
    assign rd.rd_addr = rd_addr_r;
    assign disp_data  = disp_data_r;
    assign disp_mode  = disp_mode_r;
    assign cur_idx    = cur_idx_r;
    assign rd_err     = rd_err_r;

endmodule

// File: tb/tb_disp_src_seq.sv
// Self-checking bench: vector table, randomized transactions against a transaction-level model, step/reset corner cases.
module tb_disp_src_seq;

    localparam int AW  = 5;
    localparam int NE  = 4;
    localparam int HC  = 8;
    localparam int TO  = 4;
    localparam int TO2 = 15;
    localparam logic [63:0] ERR_EXP = 64'hFFFF_FFFF_FF86_AFAF;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          run2 = 1'b0;
    logic          step2 = 1'b0;
    logic [AW-1:0] base_addr = 5'd0;
    logic [AW-1:0] base2 = 5'd0;
    logic [63:0]   disp_data, disp_data2;
    logic          disp_mode, disp_mode2;
    logic [1:0]    cur_idx, cur_idx2;
    logic          rd_err, rd_err2;

    int            checks = 0;
    int            failures = 0;
    int            exp_idx = 0;
    logic [AW-1:0] exp_base = 5'd0;
    logic          exp_err = 1'b0;

    typedef struct {
        int          lat;
        logic [31:0] data;
        logic [4:0]  addr;
        logic [1:0]  idx;
        logic [63:0] disp;
        logic        mode;
        logic        err;
    } vec_t;
    vec_t tbl [5];

    disp_src_seq_if #(.ADDR_W(AW)) m ();
    disp_src_seq_if #(.ADDR_W(AW)) m2 ();

    disp_src_seq #(.ADDR_W(AW), .NUM_ENTRIES(NE), .HOLD_CYC(HC), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .run(run), .step(step), .base_addr(base_addr), .rd(m),
        .disp_data(disp_data), .disp_mode(disp_mode), .cur_idx(cur_idx), .rd_err(rd_err)
    );

    disp_src_seq #(.ADDR_W(AW), .NUM_ENTRIES(NE), .HOLD_CYC(HC), .RD_TIMEOUT(TO2)) dut2 (
        .clk(clk), .rstn(rstn), .run(run2), .step(step2), .base_addr(base2), .rd(m2),
        .disp_data(disp_data2), .disp_mode(disp_mode2), .cur_idx(cur_idx2), .rd_err(rd_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic rst_checks();
        chk("rst_rd_req", 64'(m.rd_req), 64'(0));
        chk("rst_rd_addr", 64'(m.rd_addr), 64'(0));
        chk("rst_disp_data", disp_data, 64'h0);
        chk("rst_disp_mode", 64'(disp_mode), 64'(0));
        chk("rst_cur_idx", 64'(cur_idx), 64'(0));
        chk("rst_rd_err", 64'(rd_err), 64'(0));
    endtask

    task automatic do_reset(input logic [AW-1:0] base);
        @(negedge clk);
        rstn = 1'b0;
        m.rd_ack = 1'b0;
        base_addr = base;
        #1;
        rst_checks();
        @(negedge clk);
        rstn = 1'b1;
        exp_idx = 0;
        exp_err = 1'b0;
        exp_base = base;
    endtask

    // Wait for the next request; on an advance the model index steps and wraps
    task automatic wait_req(input bit adv, output int n);
        logic [AW-1:0] ea;
        n = 0;
        while (!m.rd_req && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 64'(m.rd_req), 64'(1));
        if (adv) exp_idx = (exp_idx + 1) % NE;
        ea = exp_base + AW'(exp_idx);
        chk("rd_addr", 64'(m.rd_addr), 64'(ea));
        chk("cur_idx", 64'(cur_idx), 64'(exp_idx));
    endtask

    // Answer the open request after lat cycles (outside 1..TO means no ack) and check the result
    task automatic serve(input int lat, input logic [31:0] data, input logic [AW-1:0] nb);
        int c;
        logic [AW-1:0] a0;
        bit stable;
        c = 0;
        a0 = m.rd_addr;
        stable = 1'b1;
        base_addr = nb;
        while (m.rd_req && c < TO + 4) begin
            c++;
            m.rd_ack = (c == lat);
            m.rd_data = (c == lat) ? data : $urandom;
            @(negedge clk);
            m.rd_ack = 1'b0;
            if (m.rd_req && m.rd_addr !== a0) stable = 1'b0;
        end
        chk("addr_stable", 64'(stable), 64'(1));
        if (lat >= 1 && lat <= TO) begin
            chk("req_len", 64'(c), 64'(lat));
            chk("disp_data", disp_data, {32'h0, data});
            chk("disp_mode", 64'(disp_mode), 64'(0));
        end else begin
            exp_err = 1'b1;
            chk("req_len_to", 64'(c), 64'(TO));
            chk("disp_err", disp_data, ERR_EXP);
            chk("disp_mode_err", 64'(disp_mode), 64'(1));
        end
        chk("rd_err", 64'(rd_err), 64'(exp_err));
        exp_base = nb;
    endtask

    task automatic count_req(input int cyc, output int k);
        k = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (m.rd_req) k++;
        end
    endtask

    initial begin
        int n;
        int k;
        m.rd_ack = 1'b0;
        m.rd_data = 32'h0;
        m2.rd_ack = 1'b0;
        m2.rd_data = 32'h0;

        tbl[0] = '{1, 32'h1111_0001, 5'd30, 2'd0, 64'h0000_0000_1111_0001, 1'b0, 1'b0};
        tbl[1] = '{2, 32'hDEAD_BEEF, 5'd31, 2'd1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0};
        tbl[2] = '{4, 32'h0000_00FF, 5'd0,  2'd2, 64'h0000_0000_0000_00FF, 1'b0, 1'b0};
        tbl[3] = '{0, 32'h0000_0000, 5'd1,  2'd3, ERR_EXP,                 1'b1, 1'b1};
        tbl[4] = '{1, 32'h0000_00A5, 5'd30, 2'd0, 64'h0000_0000_0000_00A5, 1'b0, 1'b1};

        // First read after reset, one-cycle ack
        do_reset(5'd0);
        wait_req(1'b0, n);
        serve(1, 32'h1234_5678, 5'd0);
        chk("t1_disp", disp_data, 64'h0000_0000_1234_5678);

        // Auto-advance through the wrapping window, including timeout and ack-on-timeout-cycle
        do_reset(5'd30);
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_req(i != 0, n);
            if (i != 0) chk("tbl_gap", 64'(n), 64'(HC));
            chk("tbl_addr", 64'(m.rd_addr), 64'(tbl[i].addr));
            chk("tbl_idx", 64'(cur_idx), 64'(tbl[i].idx));
            serve(tbl[i].lat, tbl[i].data, 5'd30);
            chk("tbl_disp", disp_data, tbl[i].disp);
            chk("tbl_mode", 64'(disp_mode), 64'(tbl[i].mode));
            chk("tbl_err", 64'(rd_err), 64'(tbl[i].err));
        end

        // Randomized latencies, data and base changes
        do_reset(AW'($urandom_range(0, 31)));
        for (int i = 0; i < 40; i++) begin
            wait_req(i != 0, n);
            if (i != 0) chk("rnd_gap", 64'(n), 64'(HC));
            serve(int'($urandom_range(1, 6)), $urandom, AW'($urandom_range(0, 31)));
        end

        // Manual mode: a held step level gives exactly one advance
        run = 1'b0;
        count_req(20, k);
        chk("manual_idle", 64'(k), 64'(0));
        step = 1'b1;
        wait_req(1'b1, n);
        chk_rng("step_latency", n, 3, 4);
        serve(2, 32'h0BAD_F00D, exp_base);
        count_req(90, k);
        chk("step_held", 64'(k), 64'(0));
        step = 1'b0;
        count_req(1000, k);
        chk("step_released", 64'(k), 64'(0));
        chk("manual_idx", 64'(cur_idx), 64'(exp_idx));

        // Step edge during a long REQ is dropped (second instance, longer timeout)
        base2 = 5'd7;
        do_reset(5'd0);
        n = 0;
        while (!m2.rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_req", 64'(m2.rd_req), 64'(1));
        step2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            m2.rd_ack = (c == 10);
            m2.rd_data = 32'hCAFE_0010;
            @(negedge clk);
            m2.rd_ack = 1'b0;
        end
        chk("t5_acked", 64'(m2.rd_req), 64'(0));
        chk("t5_disp", disp_data2, 64'h0000_0000_CAFE_0010);
        chk("t5_err", 64'(rd_err2), 64'(0));
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (m2.rd_req) k++;
        end
        chk("t5_dropped", 64'(k), 64'(0));
        chk("t5_idx0", 64'(cur_idx2), 64'(0));
        step2 = 1'b0;
        repeat (5) @(negedge clk);
        step2 = 1'b1;
        n = 0;
        while (!m2.rd_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t5_req2", 64'(m2.rd_req), 64'(1));
        chk("t5_idx1", 64'(cur_idx2), 64'(1));
        chk("t5_addr1", 64'(m2.rd_addr), 64'(8));
        m2.rd_ack = 1'b1;
        m2.rd_data = 32'h0000_0001;
        @(negedge clk);
        m2.rd_ack = 1'b0;
        step2 = 1'b0;
        chk("t5_done", 64'(m2.rd_req), 64'(0));

        // Reset asserted mid-REQ drops the request at once; the next read restarts the window
        do_reset(5'd9);
        wait_req(1'b0, n);
        @(negedge clk);
        chk("pre_rst_req", 64'(m.rd_req), 64'(1));
        rstn = 1'b0;
        #1;
        rst_checks();
        @(negedge clk);
        rstn = 1'b1;
        exp_idx = 0;
        exp_err = 1'b0;
        exp_base = 5'd9;
        wait_req(1'b0, n);
        serve(1, 32'h600D_0006, 5'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_src_seq.md
Name: disp_src_seq

Overview:
Upstream feeder for the 8-digit seven-segment display driver. It walks a window of a 32-bit debug read port (register file / data memory), fetching one entry at a time over a req/ack handshake. It presents the fetched word as a 64-bit display word plus display mode. Entries advance automatically on a hold timer or by a manual step button. A read that times out shows "Err" as raw segment patterns.

Parameters:
ADDR_W, 5, width of debug read address
NUM_ENTRIES, 32, entries in window; index wraps NUM_ENTRIES-1 -> 0
HOLD_CYC, 50000000, clk cycles each entry is held in auto mode
RD_TIMEOUT, 15, max cycles rd_req may stay high without rd_ack

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
run  in  1  1 = auto-advance on hold timer; 0 = manual only
step  in  1  asynchronous button level; each rising edge advances one entry
base_addr  in  ADDR_W  window start address
rd_req  out  1  read request
rd_addr  out  ADDR_W  read address, stable while rd_req=1
rd_ack  in  1  read complete; rd_data valid in same cycle
rd_data  in  32  read data
disp_data  out  64  display word to display driver i_data
disp_mode  out  1  0 = hex (low 32 bits); 1 = raw active-low segment bytes
cur_idx  out  $clog2(NUM_ENTRIES)  current window index
rd_err  out  1  sticky: some read timed out since reset

Behaviour:
- Reset (async, rstn=0):
  - state IDLE; rd_req=0; rd_addr=0; disp_data=0; disp_mode=0; cur_idx=0; rd_err=0.
  - Hold and timeout counters 0; step synchronizer flops 0.
  - rd_req drops in the same instant rstn falls, including mid-transfer.
- FSM states: IDLE, REQ, HOLD.
- IDLE: always go to REQ on the next clk. Load rd_addr = base_addr + cur_idx, modulo 2^ADDR_W.
- REQ: rd_req=1 and rd_addr held constant. Timeout counter increments each cycle rd_ack=0.
  - rd_ack=1 on a clk edge:
    - disp_data <= {32'h0, rd_data}; disp_mode <= 0; rd_req <= 0.
    - Clear hold counter; go HOLD.
    - Ack is accepted on the first REQ cycle (1-cycle minimum latency).
  - Timeout counter reaches RD_TIMEOUT with no ack:
    - rd_req <= 0; disp_mode <= 1; rd_err <= 1.
    - disp_data <= 64'hFFFF_FFFF_FF86_AFAF: digit2 'E', digits1-0 'r', others blank.
    - Go HOLD.
  - Ack in the same cycle as the timeout: ack wins.
- HOLD: hold counter increments, saturating at HOLD_CYC-1.
  - Advance condition: (run && counter == HOLD_CYC-1) || step_rise.
  - On advance:
    - cur_idx <= (cur_idx == NUM_ENTRIES-1) ? 0 : cur_idx+1.
    - rd_addr <= base_addr + new index, modulo 2^ADDR_W.
    - Go REQ.
  - run=0: remain in HOLD indefinitely until step_rise.
- step path:
  - Two-flop synchronizer, then rising-edge detect. step_rise is one clk pulse, 3 clk after the input edge.
  - A held level produces exactly one advance.
  - step_rise in REQ or IDLE is dropped, not queued.
- base_addr is sampled only when rd_addr is loaded. Changing it mid-REQ has no effect until the next advance.
- rd_err is cleared only by reset. A later successful read restores disp_mode=0 but leaves rd_err=1.
- Outputs disp_data and disp_mode are registered and change only on state exits from REQ.

Decomposition:
- Shared package disp_pkg:
  - Constants: SEG_E=8'h86, SEG_R=8'hAF, SEG_BLANK=8'hFF, ERR_WORD=64'hFFFF_FFFF_FF86_AFAF.
  - State enum: IDLE, REQ, HOLD.
- One sub-module: step_sync. Two-flop synchronizer plus rising-edge detector. Ports clk, rstn, d_async, rise. Reusable for other buttons.

Test Plan (HOLD_CYC=8, RD_TIMEOUT=4, NUM_ENTRIES=4, ADDR_W=5):
1. Release rstn, base_addr=0, memory acks 1 cycle after req with 0x12345678.
   -> rd_addr=0; disp_data=0x0000000012345678; disp_mode=0; cur_idx=0.
2. run=1, base_addr=30, memory always acks.
   -> rd_addr sequence 30, 31, 0, 1, 30; cur_idx 0, 1, 2, 3, 0.
   -> 8 HOLD cycles between ack and next rd_req.
3. Memory never acks.
   -> rd_req drops after 4 cycles; disp_data=0xFFFFFFFFFF86AFAF; disp_mode=1; rd_err=1.
   -> Next acked read (0xA5) gives disp_data=0xA5, disp_mode=0, rd_err still 1.
4. run=0; hold step high for 100 cycles.
   -> Exactly one advance, with rd_req 3-4 cycles after the step edge.
   -> No further advance for 1000 cycles.
5. Step edge while in REQ (memory acks after 10 cycles with RD_TIMEOUT=15 override).
   -> Edge ignored; cur_idx advances only on a later step.
6. Assert rstn while rd_req=1 in REQ.
   -> rd_req=0 immediately and all outputs at reset values.
   -> After release, first read is base_addr with cur_idx=0.
